// File: rtl/cache_axi_txn_limiter_pkg.sv
// std_cache_pkg: traffic classes, ID decode and the default AXI4 struct types
// used on the merged cache-subsystem master port.
package std_cache_pkg;

    localparam int unsigned NumCls = 3;
    localparam int unsigned IdW    = 6;
    localparam int unsigned AddrW  = 32;
    localparam int unsigned DataW  = 64;

    typedef enum logic [1:0] {
        CLS_DCACHE = 2'd0,
        CLS_BYPASS = 2'd1,
        CLS_ICACHE = 2'd2
    } cls_e;

    localparam logic [3:0] ID_DCACHE = 4'b0111;
    localparam logic [3:0] ID_ICACHE = 4'b0000;

    // Unknown IDs fall back to the D$ class so they are still limited.
    function automatic cls_e id_to_class(input logic [3:0] id);
        if (id == ID_DCACHE) return CLS_DCACHE;
        if (id[3])           return CLS_BYPASS;
        if (id == ID_ICACHE) return CLS_ICACHE;
        return CLS_DCACHE;
    endfunction

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
    } std_ax_t;

    typedef struct packed {
        logic [DataW-1:0]   data;
        logic [DataW/8-1:0] strb;
        logic               last;
    } std_w_t;

    typedef struct packed {
        logic [IdW-1:0] id;
        logic [1:0]     resp;
    } std_b_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
    } std_r_t;

    typedef struct packed {
        std_ax_t aw;
        logic    aw_valid;
        std_w_t  w;
        logic    w_valid;
        logic    b_ready;
        std_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } std_axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        std_b_t b;
        logic   r_valid;
        std_r_t r;
    } std_axi_rsp_t;

endpackage

// File: rtl/cache_axi_txn_limiter_counter.sv
// axi_txn_counter: saturating in-flight burst counter for one class/direction.
// Simultaneous inc/dec cancel; a decrement at zero holds 0 and flags underflow.
module axi_txn_counter #(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned CntW           = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] cnt_o,
    output logic            full_o,
    output logic            underflow_o
);

    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: single-sided events move the count, both together cancel.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && cnt_q != MaxCnt)
            cnt_d = cnt_q + 1'b1;
        else if (dec_i && !inc_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o       = cnt_q;
    assign full_o      = (cnt_q == MaxCnt);
    // A response with nothing outstanding is an error even if a new request
    // for the same class is accepted in that cycle.
    assign underflow_o = dec_i && (cnt_q == '0);

endmodule

// File: rtl/cache_axi_txn_limiter.sv
// cache_axi_txn_limiter: caps in-flight AXI bursts per traffic class and
// direction on the merged cache master port. Only AR/AW handshakes are gated;
// everything else is a zero-latency pass-through.
// Optional response watchdog: define CACHE_AXI_TIMEOUT_EN.
module cache_axi_txn_limiter
    import std_cache_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TimeoutCycles  = 1024,
    parameter type         axi_req_t      = std_axi_req_t,
    parameter type         axi_rsp_t      = std_axi_rsp_t,
    localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  axi_req_t                     slv_req_i,
    output axi_rsp_t                     slv_resp_o,
    output axi_req_t                     mst_req_o,
    input  axi_rsp_t                     mst_resp_i,
    output logic [NumCls-1:0][CntW-1:0]  rd_cnt_o,
    output logic [NumCls-1:0][CntW-1:0]  wr_cnt_o,
    output logic                         stall_o,
    output logic                         err_o,
    output logic                         timeout_o
);

    logic [NumCls-1:0][CntW-1:0] rd_cnt, wr_cnt;
    logic [NumCls-1:0]           rd_full, wr_full, rd_unf, wr_unf;
    cls_e ar_cls, aw_cls, r_cls, b_cls;
    logic ar_full, aw_full;
    logic ar_hs, aw_hs, r_last_hs, b_hs;
    logic err_q, err_d;

    assign ar_cls  = id_to_class(slv_req_i.ar.id[3:0]);
    assign aw_cls  = id_to_class(slv_req_i.aw.id[3:0]);
    assign r_cls   = id_to_class(mst_resp_i.r.id[3:0]);
    assign b_cls   = id_to_class(mst_resp_i.b.id[3:0]);
    assign ar_full = rd_full[ar_cls];
    assign aw_full = wr_full[aw_cls];

    // Pass everything through, masking only the address-channel handshakes.
    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ~ar_full;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & ~aw_full;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~ar_full;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~aw_full;
    end

    assign ar_hs     = slv_req_i.ar_valid & ~ar_full & mst_resp_i.ar_ready;
    assign aw_hs     = slv_req_i.aw_valid & ~aw_full & mst_resp_i.aw_ready;
    assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
    assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign stall_o   = (slv_req_i.ar_valid & ar_full) | (slv_req_i.aw_valid & aw_full);

    for (genvar c = 0; c < NumCls; c++) begin : g_cls
        axi_txn_counter #(.MaxOutstanding(MaxOutstanding), .CntW(CntW)) u_rd_cnt (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .inc_i       (ar_hs && (ar_cls == cls_e'(c))),
            .dec_i       (r_last_hs && (r_cls == cls_e'(c))),
            .cnt_o       (rd_cnt[c]),
            .full_o      (rd_full[c]),
            .underflow_o (rd_unf[c])
        );
        axi_txn_counter #(.MaxOutstanding(MaxOutstanding), .CntW(CntW)) u_wr_cnt (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .inc_i       (aw_hs && (aw_cls == cls_e'(c))),
            .dec_i       (b_hs && (b_cls == cls_e'(c))),
            .cnt_o       (wr_cnt[c]),
            .full_o      (wr_full[c]),
            .underflow_o (wr_unf[c])
        );
    end

    assign rd_cnt_o = rd_cnt;
    assign wr_cnt_o = wr_cnt;

    // Sticky error: any response for a class with nothing outstanding.
    always_comb begin
        err_d = err_q | (|rd_unf) | (|wr_unf);
    end

    // Error flag register; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign err_o = err_q;

`ifdef CACHE_AXI_TIMEOUT_EN
    localparam int unsigned     WdW   = $clog2(TimeoutCycles + 1);
    localparam logic [WdW-1:0]  WdMax = WdW'(TimeoutCycles - 1);

    logic           any_busy;
    logic [WdW-1:0] wd_q, wd_d;
    logic           to_q, to_d;

    assign any_busy = (|rd_cnt) | (|wr_cnt);

    // Watchdog: counts stalled cycles while anything is in flight, saturates.
    always_comb begin
        wd_d = wd_q;
        if (!any_busy || r_last_hs || b_hs)
            wd_d = '0;
        else if (wd_q != WdMax)
            wd_d = wd_q + 1'b1;
        to_d = to_q | (any_busy & (wd_d == WdMax));
    end

    // Watchdog and sticky timeout registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign timeout_o = to_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
